// File: rtl/npc_pkg.sv
// Shared encodings for the next-PC unit: redirect modes, controller states, PC step.
package npc_pkg;

  localparam logic [1:0] NPC_NONE = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam int PC_STEP = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect target and request decode for the next-PC unit.
module npc_target_calc
  import npc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int JIMM_W = 26,
  parameter int BIMM_W = 16
) (
  input  logic [ADDR_W-1:0] src_pc,
  input  logic [BIMM_W-1:0] bimm,
  input  logic [JIMM_W-1:0] jimm,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic [1:0]        redir_mode,
  input  logic              br_taken,
  output logic [ADDR_W-1:0] target,
  output logic              req
);

  logic        [ADDR_W-1:0] src_pc4;
  logic signed [BIMM_W-1:0] bimm_s;
  logic signed [ADDR_W-1:0] br_off;
  logic        [ADDR_W-1:0] br_target;
  logic        [ADDR_W-1:0] j_target;

  assign src_pc4   = src_pc + ADDR_W'(PC_STEP);
  assign bimm_s    = bimm;
  // Word offset: sign-extend to full width, then scale to bytes.
  assign br_off    = ADDR_W'(bimm_s) <<< 2;
  assign br_target = src_pc4 + $unsigned(br_off);
  assign j_target  = {src_pc4[ADDR_W-1:JIMM_W+2], jimm, 2'b00};

  always_comb begin
    target = src_pc4;
    req    = 1'b0;
    case (redir_mode)
      NPC_BR: begin
        target = br_target;
        req    = br_taken;
      end
      NPC_J: begin
        target = j_target;
        req    = 1'b1;
      end
      NPC_JR: begin
        target = jr_addr;
        req    = 1'b1;
      end
      default: begin
        target = src_pc4;
        req    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered fetch PC: sequential advance, redirects, stall hold with one-deep
// redirect buffer, and misaligned-target flagging.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                JIMM_W       = 26,
  parameter int                BIMM_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [1:0]        redir_mode,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] src_pc,
  input  logic [BIMM_W-1:0] bimm,
  input  logic [JIMM_W-1:0] jimm,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redir_taken,
  output logic              pend_valid,
  output logic              misalign_err
);

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  npc_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] live_tgt;
  logic [ADDR_W-1:0] load_tgt;
  logic              live_req;
  logic              load;

  npc_target_calc #(
    .ADDR_W(ADDR_W),
    .JIMM_W(JIMM_W),
    .BIMM_W(BIMM_W)
  ) u_target_calc (
    .src_pc    (src_pc),
    .bimm      (bimm),
    .jimm      (jimm),
    .jr_addr   (jr_addr),
    .redir_mode(redir_mode),
    .br_taken  (br_taken),
    .target    (live_tgt),
    .req       (live_req)
  );

  assign pc_plus4   = pc + ADDR_W'(PC_STEP);
  assign pend_valid = (state == PEND);

  always_comb begin
    state_nxt    = state;
    pend_tgt_nxt = pend_tgt;
    pc_nxt       = pc;
    load         = 1'b0;
    load_tgt     = live_tgt;
    case (state)
      IDLE: begin
        if (stall) begin
          if (live_req) begin
            pend_tgt_nxt = live_tgt;
            state_nxt    = PEND;
          end
        end else if (live_req) begin
          load = 1'b1;
        end else begin
          pc_nxt = pc_plus4;
        end
      end
      PEND: begin
        if (stall) begin
          if (live_req) pend_tgt_nxt = live_tgt;
        end else begin
          // A fresh request from the same slot supersedes the buffered one.
          load      = 1'b1;
          load_tgt  = live_req ? live_tgt : pend_tgt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) pc_nxt = word_align(load_tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      pend_tgt     <= '0;
      redir_taken  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      pend_tgt     <= pend_tgt_nxt;
      redir_taken  <= load;
      misalign_err <= load && (load_tgt[1:0] != 2'b00);
    end
  end

endmodule
